// File: rtl/pwm_pkg.sv
// Shared constants for the PWM pin driver.
package pwm_pkg;
  localparam int PWM_BITS        = 8;
  localparam int NUM_PINS        = 16;
  localparam logic [PWM_BITS-1:0] DUTY_FULL = 8'hFF;
  localparam int CLK_DIV_DEFAULT = 12;

  // A prescaler of CLK_DIV = 0 still needs a 1-bit counter.
  function automatic int presc_width(input int div);
    return (div < 1) ? 1 : $clog2(div + 1);
  endfunction
endpackage

// File: rtl/pwm_prescaler.sv
// Divides clk down to the PWM step rate: one-cycle step every CLK_DIV+1 clocks.
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  output logic step
);
  localparam int W = presc_width(CLK_DIV);
  localparam logic [W-1:0] TC = W'(CLK_DIV);

  logic [W-1:0] presc;

  assign step = (presc == TC);

  always_ff @(posedge clk) begin
    if (rst)       presc <= '0;
    else if (step) presc <= '0;
    else           presc <= presc + W'(1);
  end
endmodule

// File: rtl/pwm_peripheral.sv
// Drives 16 pins low, high or from one shared 8-bit PWM waveform.
// Define PWM_SYNC_UPDATE_EN to latch duty changes only at period boundaries.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          en_reg_out_7_0,
  input  logic [7:0]          en_reg_out_15_8,
  input  logic [7:0]          en_reg_pwm_7_0,
  input  logic [7:0]          en_reg_pwm_15_8,
  input  logic [7:0]          pwm_duty_cycle,
  output logic [NUM_PINS-1:0] out,
  output logic                period_tick
);
  logic                step;
  logic                wrap;
  logic                pwm_sig;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty_act;
  logic [NUM_PINS-1:0] en_out;
  logic [NUM_PINS-1:0] en_pwm;

  pwm_prescaler #(.CLK_DIV(CLK_DIV)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .step (step)
  );

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  assign wrap   = step && (pwm_cnt == {PWM_BITS{1'b1}});

  always_ff @(posedge clk) begin
    if (rst)       pwm_cnt <= '0;
    else if (step) pwm_cnt <= pwm_cnt + PWM_BITS'(1);
  end

`ifdef PWM_SYNC_UPDATE_EN
  // Shadow duty: the running period always finishes with the duty it started with.
  always_ff @(posedge clk) begin
    if (rst)       duty_act <= '0;
    else if (wrap) duty_act <= pwm_duty_cycle;
  end
`else
  assign duty_act = pwm_duty_cycle;
`endif

  // Full scale is forced high; a plain compare would leave one low step per period.
  assign pwm_sig = (duty_act == DUTY_FULL) || (pwm_cnt < duty_act);

  always_ff @(posedge clk) begin
    if (rst) begin
      out         <= '0;
      period_tick <= 1'b0;
    end else begin
      out         <= en_out & (~en_pwm | {NUM_PINS{pwm_sig}});
      period_tick <= wrap;
    end
  end
endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed bench for pwm_peripheral with default CLK_DIV (PWM period 3328 clk).
module tb_pwm_peripheral;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  eo_lo, eo_hi, ep_lo, ep_hi, duty;
  logic [15:0] out;
  logic        period_tick;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  pwm_peripheral dut (
    .clk             (clk),
    .rst             (rst),
    .en_reg_out_7_0  (eo_lo),
    .en_reg_out_15_8 (eo_hi),
    .en_reg_pwm_7_0  (ep_lo),
    .en_reg_pwm_15_8 (ep_hi),
    .pwm_duty_cycle  (duty),
    .out             (out),
    .period_tick     (period_tick)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
    {eo_hi, eo_lo} = eo;
    {ep_hi, ep_lo} = ep;
  endtask

  task automatic wait_ptick();
    int n = 0;
    do begin
      tick();
      n++;
    end while (!period_tick && n < 4000);
    if (!period_tick) check_eq("ptick_timeout", 0, 1);
  endtask

  task automatic count_high(input int n, output int hi);
    hi = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (out[0]) hi++;
    end
  endtask

  task automatic count_ne(input int n, input logic [15:0] v, output int bad);
    bad = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (out !== v) bad++;
    end
  endtask

  task automatic wait_bit(input logic lvl, output int at);
    int n = 0;
    while (out[0] !== lvl && n < 4000) begin
      tick();
      n++;
    end
    if (out[0] !== lvl) check_eq("edge_timeout", 0, 1);
    at = cyc;
  endtask

  initial begin
    int n, hi, bad, r1, f1, r2;
    int exp_n100, exp_mid;

`ifdef PWM_SYNC_UPDATE_EN
    exp_n100 = 0;
    exp_mid  = 832;
`else
    exp_n100 = 16'hFFFF;
    exp_mid  = 2028;
`endif

    rst = 1'b1;
    set_en(16'hFFFF, 16'hFFFF);
    duty = 8'hFF;
    repeat (3) tick();
    check_eq("rst_out", int'(out), 0);
    check_eq("rst_ptick", int'(period_tick), 0);

    rst = 1'b0;
    n = 0;
    while (n < 4000) begin
      tick();
      n++;
      if (n == 100) check_eq("first_period_out", int'(out), exp_n100);
      if (period_tick) break;
    end
    check_eq("first_ptick_delay", n, 3328);
    tick();
    check_eq("after_load_out", int'(out), 16'hFFFF);

    set_en(16'h00FF, 16'h0000);
    tick();
    check_eq("static_latency", int'(out), 16'h00FF);
    count_ne(6656, 16'h00FF, bad);
    check_eq("static_hold", bad, 0);

    set_en(16'h0001, 16'h0001);
    duty = 8'h80;
    wait_ptick();
    count_high(3328, hi);
    check_eq("d80_high_total", hi, 1664);
    wait_bit(1'b0, r1);
    wait_bit(1'b1, r1);
    wait_bit(1'b0, f1);
    wait_bit(1'b1, r2);
    check_eq("d80_pulse", f1 - r1, 1664);
    check_eq("d80_period", r2 - r1, 3328);

    duty = 8'h00;
    wait_ptick();
    count_high(6656, hi);
    check_eq("d00_high", hi, 0);

    duty = 8'hFF;
    wait_ptick();
    count_high(6656, hi);
    check_eq("dff_high", hi, 6656);

    set_en(16'h0000, 16'hFFFF);
    duty = 8'h80;
    tick();
    count_ne(3328, 16'h0000, bad);
    check_eq("disable_override", bad, 0);

    set_en(16'h0001, 16'h0001);
    duty = 8'h40;
    wait_ptick();
    hi = 0;
    for (int k = 1; k <= 3328; k++) begin
      tick();
      if (out[0]) hi++;
      if (k == 1300) duty = 8'hC0;
    end
    check_eq("mid_change_cur", hi, exp_mid);
    count_high(3328, hi);
    check_eq("mid_change_next", hi, 2496);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
